// File: rtl/pe_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters and the PE-array round-robin arbiter.
// The master side drives requests and done; the slave side (the arbiter) returns the grant.
interface pe_rr_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic                 done;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 grant_valid;
    logic                 timeout_err;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout_err
    );
endinterface

// File: rtl/pe_rr_arbiter.sv
// Round-robin arbiter for a shared PE-array resource: one grantee at a time, held until done,
// abandon or hold-watchdog timeout, with same-cycle re-arbitration on release.
module pe_rr_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = $clog2(NUM_REQ),
    parameter int MAX_HOLD  = 256,
    parameter int CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    pe_rr_arbiter_if.slave   arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(NUM_REQ - 1);
    localparam logic [IDX_WIDTH:0]   NUM_REQ_W  = (IDX_WIDTH + 1)'(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(MAX_HOLD - 1);

    state_t               state_reg, state_next;
    logic [IDX_WIDTH-1:0] ptr_reg, ptr_next;
    logic [CNT_WIDTH-1:0] hold_cnt_reg, hold_cnt_next;
    logic [IDX_WIDTH-1:0] grant_idx_reg, grant_idx_next;
    logic                 grant_valid_reg, grant_valid_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic                 timeout_err_reg, timeout_err_next;

    logic                 hold_timeout;
    logic                 release_evt;
    logic [IDX_WIDTH-1:0] rel_ptr;

    logic [IDX_WIDTH-1:0] arb_ptr;
    logic [NUM_REQ-1:0]   arb_req;
    logic [IDX_WIDTH-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_req;
    logic                 arb_found;
    logic [IDX_WIDTH-1:0] arb_idx;

    assign hold_timeout = (hold_cnt_reg == HOLD_LAST);
    assign release_evt  = arb.done || !arb.req[grant_idx_reg] || hold_timeout;
    assign rel_ptr      = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;

    // In GRANT the arbiter only matters on release, where it starts after the releasing
    // index and excludes it, so a re-requesting grantee queues behind everyone else.
    assign arb_ptr = (state_reg == GRANT) ? rel_ptr : ptr_reg;
    assign arb_req = (state_reg == GRANT) ? (arb.req & ~grant_reg) : arb.req;

    // Candidate gi is the requester gi places after the pointer, wrapped without a modulo.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_WIDTH:0] sum;
            assign sum          = {1'b0, arb_ptr} + (IDX_WIDTH + 1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_WIDTH'(sum - NUM_REQ_W)
                                                     : IDX_WIDTH'(sum);
            assign cand_req[gi] = arb_req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        hold_cnt_next    = hold_cnt_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        timeout_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next       = GRANT;
                    grant_idx_next   = arb_idx;
                    grant_valid_next = 1'b1;
                    hold_cnt_next    = '0;
                end
            end
            GRANT: begin
                if (release_evt) begin
                    ptr_next         = rel_ptr;
                    hold_cnt_next    = '0;
                    timeout_err_next = hold_timeout;
                    if (arb_found) begin
                        grant_idx_next   = arb_idx;
                        grant_valid_next = 1'b1;
                    end else begin
                        grant_valid_next = 1'b0;
                        state_next       = IDLE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next       = IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_next[gi] = grant_valid_next && (grant_idx_next == IDX_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            hold_cnt_reg    <= '0;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            grant_reg       <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            hold_cnt_reg    <= hold_cnt_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
            grant_reg       <= grant_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign arb.grant       = grant_reg;
    assign arb.grant_idx   = grant_idx_reg;
    assign arb.grant_valid = grant_valid_reg;
    assign arb.timeout_err = timeout_err_reg;

endmodule
